// File: rtl/hub_access_seq.sv
// Round-robin hub memory sequencer for 8 cogs: issue, access and complete
// stages, each advanced by ena_bus, with one-clock ack pulses per cog.
module hub_access_seq (
  input  logic         clk_cog,
  input  logic         nres,
  input  logic         ena_bus,
  input  logic [7:0]   req,
  input  logic [7:0]   req_w,
  input  logic [15:0]  req_sz,
  input  logic [127:0] req_a,
  input  logic [255:0] req_d,
  output logic         mem_w,
  output logic [3:0]   mem_wb,
  output logic [13:0]  mem_a,
  output logic [31:0]  mem_d,
  input  logic [31:0]  mem_q,
  output logic [2:0]   slot,
  output logic [7:0]   ack,
  output logic [31:0]  rd_data
);

  // Handshake: a cog raises req[c] with its fields stable and holds it until
  // ack[c] pulses; the access is captured when slot==c and that cog has
  // nothing in flight, and dropping req after capture does not cancel it.

  logic [1:0]  cur_sz;
  logic [15:0] cur_a;
  logic [31:0] cur_d;
  logic        cur_w;
  logic        cur_busy;
  logic        issue;
  logic [3:0]  cur_wb;
  logic [31:0] cur_lanes;

  // Tracking for the command the memory is performing this slot.
  logic        acc_v;
  logic [2:0]  acc_cog;
  logic [1:0]  acc_sz;
  logic [1:0]  acc_off;
  logic        acc_w;

  // Tracking for the command whose read data arrives for completion.
  logic        cpl_v;
  logic [2:0]  cpl_cog;
  logic [1:0]  cpl_sz;
  logic [1:0]  cpl_off;
  logic        cpl_w;

  logic [31:0] rd_next;

  always_comb begin
    cur_sz   = req_sz[{slot, 1'b0} +: 2];
    cur_a    = req_a[{slot, 4'b0000} +: 16];
    cur_d    = req_d[{slot, 5'b00000} +: 32];
    cur_w    = req_w[slot];
    cur_busy = (acc_v && (acc_cog == slot)) || (cpl_v && (cpl_cog == slot));
    issue    = req[slot] && !cur_busy;
  end

  // Byte enables and lane replication; word/long drop the low address bits.
  always_comb begin
    cur_wb    = 4'b0000;
    cur_lanes = cur_d;
    if (cur_sz[1]) begin
      cur_lanes = cur_d;
      if (cur_w) cur_wb = 4'b1111;
    end else if (cur_sz[0]) begin
      cur_lanes = {2{cur_d[15:0]}};
      if (cur_w) cur_wb = cur_a[1] ? 4'b1100 : 4'b0011;
    end else begin
      cur_lanes = {4{cur_d[7:0]}};
      if (cur_w) cur_wb = 4'b0001 << cur_a[1:0];
    end
  end

  // Right-justify the read lane selected by the completing command.
  always_comb begin
    rd_next = '0;
    if (cpl_sz[1]) begin
      rd_next = mem_q;
    end else if (cpl_sz[0]) begin
      rd_next[15:0] = mem_q[{cpl_off[1], 4'b0000} +: 16];
    end else begin
      rd_next[7:0] = mem_q[{cpl_off, 3'b000} +: 8];
    end
  end

  always_ff @(posedge clk_cog or negedge nres) begin
    if (!nres) begin
      slot    <= '0;
      ack     <= '0;
      rd_data <= '0;
      mem_w   <= 1'b0;
      mem_wb  <= '0;
      mem_a   <= '0;
      mem_d   <= '0;
      acc_v   <= 1'b0;
      acc_cog <= '0;
      acc_sz  <= '0;
      acc_off <= '0;
      acc_w   <= 1'b0;
      cpl_v   <= 1'b0;
      cpl_cog <= '0;
      cpl_sz  <= '0;
      cpl_off <= '0;
      cpl_w   <= 1'b0;
    end else begin
      ack <= '0;
      if (ena_bus) begin
        slot <= slot + 3'd1;

        if (issue) begin
          mem_w  <= cur_w;
          mem_wb <= cur_wb;
          mem_a  <= cur_a[15:2];
          mem_d  <= cur_lanes;
        end else begin
          mem_w  <= 1'b0;
          mem_wb <= 4'b0000;
        end

        acc_v   <= issue;
        acc_cog <= slot;
        acc_sz  <= cur_sz;
        acc_off <= cur_a[1:0];
        acc_w   <= cur_w;

        cpl_v   <= acc_v;
        cpl_cog <= acc_cog;
        cpl_sz  <= acc_sz;
        cpl_off <= acc_off;
        cpl_w   <= acc_w;

        // Writes ack the same way but leave the last read result in place.
        if (cpl_v) begin
          ack <= 8'b0000_0001 << cpl_cog;
          if (!cpl_w) rd_data <= rd_next;
        end
      end
    end
  end

endmodule
